// File: rtl/sys_pll_sup_pkg.sv
// Shared state encoding and parameter defaults for the system PLL lock supervisor.
package sys_pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } sup_state_e;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 50000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_CNT_W         = 8;
    localparam int DEF_MAX_RETRIES   = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sys_pll_lock_supervisor_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff
    import sys_pll_sup_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sys_pll_lock_supervisor.sv
// PLL reset/lock sequencer producing a clean system reset from the 50 MHz refclk.
// Optional retry limit with sticky failure: define SYS_PLL_SUPERVISOR_RETRY_LIMIT_EN.
module sys_pll_lock_supervisor
    import sys_pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic             refclk,
    input  logic             reset_n,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_reset_n,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] loss_count,
    output logic             pll_fail
);

    localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int TMR_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [TMR_W-1:0] RST_LOAD = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STB_LOAD = TMR_W'(STABLE_CYCLES - 1);

    if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 || CNT_W < 1 || MAX_RETRIES < 0)
    begin : g_param_chk
        $error("sys_pll_lock_supervisor: illegal parameter value");
    end

    sup_state_e       state_q, state_d;
    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sysn_q, sysn_d;
    logic             lk_s;

`ifdef SYS_PLL_SUPERVISOR_RETRY_LIMIT_EN
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    logic [RETRY_W-1:0] retries_q, retries_d;
    logic               fail_q, fail_d;
`endif

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (reset_n),
        .d_i   (pll_locked),
        .q_o   (lk_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
`ifdef SYS_PLL_SUPERVISOR_RETRY_LIMIT_EN
        retries_d = retries_q;
        fail_d    = fail_q;
`endif
        case (state_q)
            PLL_RESET: begin
                if (cnt_q == '0) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TMO_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // Lock wins over a coincident timeout.
            WAIT_LOCK: begin
                if (lk_s) begin
                    state_d = STABLE;
                    cnt_d   = STB_LOAD;
                end else if (cnt_q == '0) begin
`ifdef SYS_PLL_SUPERVISOR_RETRY_LIMIT_EN
                    if (retries_q >= RETRY_W'(MAX_RETRIES)) begin
                        state_d = FAIL;
                        cnt_d   = '0;
                        fail_d  = 1'b1;
                    end else begin
                        state_d   = PLL_RESET;
                        cnt_d     = RST_LOAD;
                        retries_d = retries_q + 1'b1;
                    end
`else
                    state_d = PLL_RESET;
                    cnt_d   = RST_LOAD;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STABLE: begin
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = TMO_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                    cnt_d   = '0;
`ifdef SYS_PLL_SUPERVISOR_RETRY_LIMIT_EN
                    retries_d = '0;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RUN: begin
                if (!lk_s) begin
                    state_d = PLL_RESET;
                    cnt_d   = RST_LOAD;
                    if (loss_q != '1) begin
                        loss_d = loss_q + 1'b1;
                    end
                end
            end
            default: begin
`ifdef SYS_PLL_SUPERVISOR_RETRY_LIMIT_EN
                state_d = FAIL;
                cnt_d   = '0;
                fail_d  = 1'b1;
`else
                state_d = PLL_RESET;
                cnt_d   = RST_LOAD;
`endif
            end
        endcase

        // Output flops follow the next state so they change on the same edge as the state.
        pll_rst_d = (state_d == PLL_RESET) || (state_d == FAIL);
        sysn_d    = (state_d == RUN);
    end

    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= PLL_RESET;
            cnt_q     <= RST_LOAD;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            sysn_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            loss_q    <= loss_d;
            pll_rst_q <= pll_rst_d;
            sysn_q    <= sysn_d;
        end
    end

`ifdef SYS_PLL_SUPERVISOR_RETRY_LIMIT_EN
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            retries_q <= '0;
            fail_q    <= 1'b0;
        end else begin
            retries_q <= retries_d;
            fail_q    <= fail_d;
        end
    end

    assign pll_fail = fail_q;
`else
    assign pll_fail = 1'b0;
`endif

    assign pll_rst     = pll_rst_q;
    assign sys_reset_n = sysn_q;
    assign state_o     = state_q;
    assign loss_count  = loss_q;

endmodule
